// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong round/score sequencer with frame-rate button handling
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       start_n,
    input  logic       pause_n,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [2:0] state,
    output logic       round_rst,
    output logic       ball_en,
    output logic       paddle_en,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_POINT = 3'd4,
        S_OVER  = 3'd5
    } state_e;

    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam logic [6:0] SERVE_LOAD = 7'(SERVE_FRAMES);
    localparam logic [6:0] POINT_LOAD = 7'(POINT_FRAMES);

    // Input conditioning: previous vsync, two-flop button synchronizers,
    // and the button level captured at the previous frame tick.
    logic vsync_q;
    logic start_s1_q, start_s2_q, start_last_q;
    logic pause_s1_q, pause_s2_q, pause_last_q;

    logic frame_tick;
    logic start_press;
    logic pause_press;

    // Game state and registered outputs.
    state_e     state_q, state_d;
    logic [6:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] score_left_q, score_left_d;
    logic [3:0] score_right_q, score_right_d;
    logic       serve_dir_q, serve_dir_d;
    logic       round_rst_q, round_rst_d;
    logic       ball_en_q, ball_en_d;
    logic       paddle_en_q, paddle_en_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;

    // Scores stop at the winning value instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN) ? WIN : s + 4'd1;
    endfunction

    // Falling edge of the active-low vsync marks the start of a frame.
    assign frame_tick = vsync_q & ~vsync;

    // A press is a 1->0 change between two consecutive frame-tick samples,
    // which debounces the buttons at frame rate and yields one press per hold.
    assign start_press = frame_tick & ~start_s2_q & start_last_q;
    assign pause_press = frame_tick & ~pause_s2_q & pause_last_q;

    // Synchronize buttons, remember last vsync and last per-frame button samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q      <= 1'b1;
            start_s1_q   <= 1'b1;
            start_s2_q   <= 1'b1;
            start_last_q <= 1'b1;
            pause_s1_q   <= 1'b1;
            pause_s2_q   <= 1'b1;
            pause_last_q <= 1'b1;
        end else begin
            vsync_q    <= vsync;
            start_s1_q <= start_n;
            start_s2_q <= start_s1_q;
            pause_s1_q <= pause_n;
            pause_s2_q <= pause_s1_q;
            if (frame_tick) begin
                start_last_q <= start_s2_q;
                pause_last_q <= pause_s2_q;
            end
        end
    end

    // Register the game state, counters, scores and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            frame_cnt_q   <= 7'd0;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            serve_dir_q   <= 1'b1;
            round_rst_q   <= 1'b1;
            ball_en_q     <= 1'b0;
            paddle_en_q   <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            serve_dir_q   <= serve_dir_d;
            round_rst_q   <= round_rst_d;
            ball_en_q     <= ball_en_d;
            paddle_en_q   <= paddle_en_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
        end
    end

    // Next-state, score and output decode; outputs follow the next state so
    // they change on the same edge as the state register.
    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        serve_dir_d   = serve_dir_q;

        case (state_q)
            S_IDLE: begin
                if (start_press) begin
                    state_d       = S_SERVE;
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    serve_dir_d   = 1'b1;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (frame_cnt_q != 7'd0) begin
                        frame_cnt_d = frame_cnt_q - 7'd1;
                    end
                    if (frame_cnt_q <= 7'd1) begin
                        state_d = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (miss_left && miss_right) begin
                    // Both sides missed on the same clock: replay the serve.
                    state_d = S_SERVE;
                end else if (miss_left) begin
                    score_right_d = sat_inc(score_right_q);
                    serve_dir_d   = 1'b0;
                    state_d       = S_POINT;
                end else if (miss_right) begin
                    score_left_d = sat_inc(score_left_q);
                    serve_dir_d  = 1'b1;
                    state_d      = S_POINT;
                end else if (pause_press) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                // Resume wins if both buttons register on the same tick.
                if (pause_press) begin
                    state_d = S_PLAY;
                end else if (start_press) begin
                    state_d = S_IDLE;
                end
            end
            S_POINT: begin
                if (frame_tick) begin
                    if (frame_cnt_q != 7'd0) begin
                        frame_cnt_d = frame_cnt_q - 7'd1;
                    end
                    if (frame_cnt_q <= 7'd1) begin
                        if (score_left_q == WIN || score_right_q == WIN) begin
                            state_d = S_OVER;
                        end else begin
                            state_d = S_SERVE;
                        end
                    end
                end
            end
            S_OVER: begin
                if (start_press) begin
                    state_d       = S_SERVE;
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    serve_dir_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frame countdowns are armed on entry to the timed states.
        if (state_d == S_SERVE && state_q != S_SERVE) begin
            frame_cnt_d = SERVE_LOAD;
        end else if (state_d == S_POINT && state_q != S_POINT) begin
            frame_cnt_d = POINT_LOAD;
        end

        round_rst_d = (state_d == S_IDLE) || (state_d == S_SERVE && state_q != S_SERVE);
        ball_en_d   = (state_d == S_PLAY);
        paddle_en_d = (state_d == S_SERVE) || (state_d == S_PLAY);
        game_over_d = (state_d == S_OVER);
        winner_d    = (state_d == S_OVER) && (score_right_d == WIN);
    end

    assign state       = state_q;
    assign round_rst   = round_rst_q;
    assign ball_en     = ball_en_q;
    assign paddle_en   = paddle_en_q;
    assign serve_dir   = serve_dir_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Top-level game sequencer for Pong. Runs the round/score state machine, gates the ball and paddle datapaths, keeps both 4-bit scores, and issues the round-reset pulse that recentres the paddles and ball. Sits between the VGA timing generator (vsync), the two paddle blocks, the ball block and the score display.

## Interface

Parameters:
- WIN_SCORE, 7, points needed to win (1..15).
- SERVE_FRAMES, 60, frames the ball is held before each serve (1..127).
- POINT_FRAMES, 90, frames of freeze after a point is scored (1..127).

Ports:
- clk  in  1  pixel clock (25 MHz); all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- vsync  in  1  VGA vertical sync, active-low, synchronous to clk.
- start_n  in  1  start button, active-low, asynchronous.
- pause_n  in  1  pause button, active-low, asynchronous.
- miss_left  in  1  one-clk pulse from ball block: ball passed left paddle.
- miss_right  in  1  one-clk pulse from ball block: ball passed right paddle.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5.
- round_rst  out  1  active-high reset to paddles and ball.
- ball_en  out  1  ball may move.
- paddle_en  out  1  paddles may move.
- serve_dir  out  1  0 = serve toward left player, 1 = toward right.
- score_left  out  4  left player score.
- score_right  out  4  right player score.
- game_over  out  1  high in OVER.
- winner  out  1  0 = left, 1 = right; valid while game_over.

## Operation

- frame_tick: one-clk pulse on clk where registered previous vsync = 1 and current vsync = 0.
- Buttons: 2-flop synchronizer each; sampled only on frame_tick. Press = sampled 0 on this tick and 1 on previous tick (one press per frame-rate edge, frame-rate debounce). Presses in states that ignore them are discarded, not queued.
- frame_cnt: 7-bit down-counter, loaded on entry to SERVE/POINT, decremented on frame_tick.
- IDLE: round_rst=1, ball_en=0, paddle_en=0. start press -> SERVE; scores cleared to 0, serve_dir=1.
- SERVE: round_rst=1 for exactly the first clk in state, then 0; paddle_en=1, ball_en=0. After SERVE_FRAMES frame_ticks -> PLAY. pause ignored.
- PLAY: ball_en=1, paddle_en=1. Priority: simultaneous miss_left & miss_right -> SERVE, no score change, serve_dir unchanged. miss_left alone -> score_right+1, serve_dir=0, -> POINT. miss_right alone -> score_left+1, serve_dir=1, -> POINT. Else pause press -> PAUSE.
- PAUSE: ball_en=0, paddle_en=0; miss pulses ignored; pause press -> PLAY; start press -> IDLE.
- POINT: ball_en=0, paddle_en=0. After POINT_FRAMES frame_ticks: if either score == WIN_SCORE -> OVER, else -> SERVE.
- OVER: game_over=1, winner = 1 if score_right == WIN_SCORE else 0; scores held; ball_en=paddle_en=0. start press -> SERVE with scores cleared, serve_dir=1.
- Scores saturate at WIN_SCORE (never exceed; no wrap).
- start press in SERVE/PLAY/POINT ignored.

## Timing

- All outputs registered; reset values: state=IDLE, round_rst=1, ball_en=0, paddle_en=0, serve_dir=1, scores=0, game_over=0, winner=0, frame_cnt=0, synchronizers and previous-sample regs=1 (released).
- Button latency: edge on pin -> action at the frame_tick after 2 clk of synchronization; press shorter than the gap between two frame ticks may be missed (intended).
- State change and score update occur on the same clk edge that samples the triggering miss pulse or frame_tick; outputs reflect new state one clk later than that edge's inputs (registered).
- SERVE to PLAY: exactly SERVE_FRAMES frame_ticks after entry; the tick arriving in the entry clk is counted.
- Reset asserted mid-game: all state immediately to reset values (async); release returns to IDLE.

## Test plan

- Reset/idle: assert rst mid-PLAY -> state=0, round_rst=1, ball_en=0, scores 0 immediately; no frame_ticks -> stays IDLE.
- Serve timing: SERVE_FRAMES=3, start press -> round_rst high 1 clk, state=SERVE; PLAY reached on 3rd frame_tick, ball_en=1.
- Scoring: in PLAY pulse miss_left -> score_right=1, serve_dir=0, POINT; after POINT_FRAMES ticks -> SERVE.
- Simultaneous miss: miss_left and miss_right same clk -> scores unchanged, state=SERVE.
- Win: WIN_SCORE=2, two miss_right points -> OVER, game_over=1, winner=0, score_left=2; extra miss pulses ignored; start -> scores 0, SERVE.
- Pause: pause press in PLAY -> PAUSE, ball_en=paddle_en=0, miss_left ignored; second press -> PLAY, score unchanged; press held low across many ticks counts once.
